tape_player_tx: RTL



---
 rtl/tape_pkg.sv | 32 +++
 rtl/tape_bit_cell.sv | 79 +++++++
 rtl/tape_player_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// tape_pkg: shared types and constants for the Oric tape transmitter.
// FSM states, frame index layout and default cell timing.
package tape_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_MARK,
    ST_FRAME
  } tape_state_t;

  localparam logic [3:0] IDX_START  = 4'd0;
  localparam logic [3:0] IDX_PARITY = 4'd9;

  localparam int HALF_US_DEF     = 208;
  localparam int ZERO_LOW_US_DEF = 416;
  localparam int STOP_BITS_DEF   = 4;

  // Level carried by frame cell i for byte d.
  // Cells past the parity slot are stop '1's.
  function automatic logic frame_bit(
    input logic [3:0] i,
    input logic [7:0] d
  );
    logic [3:0] k;
    k = i - 4'd1;
    if (i == IDX_START) return 1'b0;
    if (i < IDX_PARITY) return d[k[2:0]];
    if (i == IDX_PARITY) return ~^d;
    return 1'b1;
  endfunction

endpackage

// File: rtl/tape_bit_cell.sv
// tape_bit_cell: one tape bit cell, high phase then low phase.
// Owns the tick counter and the slow-format repeat counter.
module tape_bit_cell
  import tape_pkg::*;
#(
  parameter int HALF_US     = HALF_US_DEF,
  parameter int ZERO_LOW_US = ZERO_LOW_US_DEF
) (
  input  logic CLK_IN,
  input  logic RESETn,
  input  logic ena,
  input  logic clear,
  input  logic start,
  input  logic bit_val,
  input  logic slow,
  output logic tape_out,
  output logic cell_done
);

  localparam logic [9:0] ONE_M1  = 10'(HALF_US - 1);
  localparam logic [9:0] ZERO_M1 = 10'(ZERO_LOW_US - 1);

  logic       active;
  logic       phase_hi;
  logic       bit_q;
  logic       slow_q;
  logic [9:0] cnt;
  logic [2:0] cyc;
  logic [9:0] low_m1;
  logic [9:0] high_m1;

  // Phase lengths and end-of-cell strobe for the latched bit.
  always_comb begin
    low_m1  = bit_q ? ONE_M1 : ZERO_M1;
    high_m1 = (slow_q && !bit_q) ? ZERO_M1 : ONE_M1;
    cell_done = ena && active && !phase_hi
             && (cnt == 10'd0) && (cyc == 3'd0);
  end

  // Count ticks through high/low phases, repeating in slow mode.
  always_ff @(posedge CLK_IN) begin
    if (!RESETn || clear) begin
      active   <= 1'b0;
      phase_hi <= 1'b0;
      bit_q    <= 1'b0;
      slow_q   <= 1'b0;
      cnt      <= 10'd0;
      cyc      <= 3'd0;
      tape_out <= 1'b0;
    end else if (ena) begin
      if (start) begin
        active   <= 1'b1;
        phase_hi <= 1'b1;
        bit_q    <= bit_val;
        slow_q   <= slow;
        cnt      <= (slow && !bit_val) ? ZERO_M1 : ONE_M1;
        cyc      <= slow ? (bit_val ? 3'd7 : 3'd3) : 3'd0;
        tape_out <= 1'b1;
      end else if (active) begin
        if (cnt != 10'd0) begin
          cnt <= cnt - 10'd1;
        end else if (phase_hi) begin
          phase_hi <= 1'b0;
          cnt      <= low_m1;
          tape_out <= 1'b0;
        end else if (cyc != 3'd0) begin
          cyc      <= cyc - 3'd1;
          phase_hi <= 1'b1;
          cnt      <= high_m1;
          tape_out <= 1'b1;
        end else begin
          active   <= 1'b0;
          tape_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/tape_player_tx.sv
// tape_player_tx: byte stream to Oric tape waveform on K7_TAPEIN.
// Optional slow format behind macro TAPE_SLOW_EN (adds port slow).
module tape_player_tx
  import tape_pkg::*;
#(
  parameter int HALF_US     = HALF_US_DEF,
  parameter int ZERO_LOW_US = ZERO_LOW_US_DEF,
  parameter int STOP_BITS   = STOP_BITS_DEF
) (
  input  logic       CLK_IN,
  input  logic       RESETn,
  input  logic       ENA_1MHZ,
  input  logic       motor,
`ifdef TAPE_SLOW_EN
  input  logic       slow,
`endif
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tape_out,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [3:0] IDX_LAST =
    4'(int'(IDX_PARITY) + STOP_BITS);

  tape_state_t state;
  logic [3:0]  idx;
  logic [7:0]  data_q;
  logic [7:0]  pend_data;
  logic        pending;
  logic        slow_q;
  logic        slow_in;
  logic        cell_done;
  logic        cell_start;
  logic        next_bit;
  logic        next_slow;
  logic        take;
  logic        frame_end;
  logic        frame_go;
  logic        pend_next;

`ifdef TAPE_SLOW_EN
  assign slow_in = slow;
`else
  assign slow_in = 1'b0;
`endif

  assign take = byte_valid && byte_ready;

  // Choose the level and format of the cell that starts this tick.
  always_comb begin
    frame_end  = (state == ST_FRAME) && cell_done
              && (idx == IDX_LAST);
    frame_go   = cell_done && pending
              && ((state == ST_MARK) || frame_end);
    cell_start = motor && (cell_done
              || ((state == ST_OFF) && ENA_1MHZ));
    pend_next  = (pending && !frame_go) || take;
    next_bit   = 1'b1;
    next_slow  = slow_in;
    unique case (1'b1)
      frame_go: next_bit = 1'b0;
      (state == ST_FRAME) && !frame_end: begin
        next_bit  = frame_bit(idx + 4'd1, data_q);
        next_slow = slow_q;
      end
      default: ;
    endcase
  end

  tape_bit_cell #(
    .HALF_US    (HALF_US),
    .ZERO_LOW_US(ZERO_LOW_US)
  ) u_cell (
    .CLK_IN   (CLK_IN),
    .RESETn   (RESETn),
    .ena      (ENA_1MHZ),
    .clear    (!motor),
    .start    (cell_start),
    .bit_val  (next_bit),
    .slow     (next_slow),
    .tape_out (tape_out),
    .cell_done(cell_done)
  );

  // Frame sequencer and handshake; losing the motor aborts at once.
  // A free pending slot is offered in MARK and FRAME alike, so the
  // next byte can queue behind the frame in flight.
  always_ff @(posedge CLK_IN) begin
    if (!RESETn || !motor) begin
      state      <= ST_OFF;
      idx        <= 4'd0;
      data_q     <= 8'd0;
      pend_data  <= 8'd0;
      pending    <= 1'b0;
      slow_q     <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      pending    <= pend_next;
      byte_ready <= !pend_next
                 && ((state != ST_OFF) || ENA_1MHZ);
      if (take) pend_data <= byte_data;
      if (frame_go) begin
        state  <= ST_FRAME;
        idx    <= IDX_START;
        data_q <= pend_data;
        slow_q <= slow_in;
        busy   <= 1'b1;
      end else if (frame_end) begin
        state <= ST_MARK;
        busy  <= 1'b0;
      end else if ((state == ST_FRAME) && cell_done) begin
        idx <= idx + 4'd1;
      end else if ((state == ST_OFF) && ENA_1MHZ) begin
        state <= ST_MARK;
      end
    end
  end

endmodule
